order_ingress_scheduler: RTL and testbench

Shares the single order input port of order_book_top between NUM_REQ order sources (for example the UDP payload extractor and the local strategy) and the book-dump trigger. Orders are granted round-robin, and dumps take priority when pending. Every issue is paced against engine_busy so that an order or a dump is never presented while the book is still processing. The block sits between the ingress sources and order_book_top.

---
 rtl/order_ingress_scheduler_pkg.sv | 29 ++
 rtl/order_ingress_scheduler_rr_arbiter.sv | 50 +++++
 rtl/order_ingress_scheduler.sv | 175 +++++++++++++++++
 tb/tb_order_ingress_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_ingress_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// order_ingress_scheduler_pkg
// Shared definitions for the order ingress scheduler and its round-robin
// arbiter: order word width, grant index width, scheduler state encodings
// and the modular index helper used by the arbiter.
// ---------------------------------------------------------------------------
package order_ingress_scheduler_pkg;

    localparam int ORDER_W = 32;   // {Price, IsBuy, ID, Qty}
    localparam int GRANT_W = 3;    // enough for up to 8 requesters

    typedef enum logic [1:0] {
        SCH_IDLE      = 2'd0,
        SCH_SETTLE    = 2'd1,
        SCH_WAIT_IDLE = 2'd2
    } sch_state_t;

    // (ptr + offset) mod n, returned as a grant index
    function automatic logic [GRANT_W-1:0] rr_next_idx(
        input logic [GRANT_W-1:0] ptr,
        input int                 offset,
        input int                 n
    );
        int sum;
        sum = int'(ptr) + offset;
        return GRANT_W'(sum % n);
    endfunction

endpackage

// File: rtl/order_ingress_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// order_ingress_scheduler_rr_arbiter (rr_arbiter)
// Purely combinational round-robin arbiter. The search starts at ptr+1 and
// wraps, so the previous winner (ptr) is considered last.
// Ports:
//   i_req        per-requester request
//   i_ptr        index of the previous winner
//   o_grant      one-hot grant (zero when no request)
//   o_grant_idx  index of the granted requester
//   o_any        at least one request present
// ---------------------------------------------------------------------------
module order_ingress_scheduler_rr_arbiter
    import order_ingress_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [GRANT_W-1:0] o_grant_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_grant;
    logic [GRANT_W-1:0] w_idx;
    logic               w_any;
    logic [GRANT_W-1:0] w_cand;
    logic               w_hit;

    // Rotate-and-priority-encode: first request found after ptr wins
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_cand  = '0;
        w_hit   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand  = rr_next_idx(i_ptr, k, NUM_REQ);
            w_hit   = (|(i_req & (NUM_REQ'(1) << w_cand))) & ~w_any;
            w_grant = w_hit ? (NUM_REQ'(1) << w_cand) : w_grant;
            w_idx   = w_hit ? w_cand : w_idx;
            w_any   = w_any | w_hit;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_any       = w_any;

endmodule

// File: rtl/order_ingress_scheduler.sv
// ---------------------------------------------------------------------------
// order_ingress_scheduler
// Shares the single order input of order_book_top between NUM_REQ order
// sources and the book-dump trigger. Orders are granted round-robin, a
// pending dump wins over orders, and every issue is followed by a settle
// window and a wait for engine_busy to drop, so only one operation is ever
// outstanding.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         per-requester order valid
//   i_req_data          per-requester order words, requester i at [32i+31:32i]
//   o_req_ready         per-requester accept (one-hot or zero, combinational)
//   i_dump_req          single-cycle dump request pulse
//   o_dump_done         single-cycle pulse when the dump has completed
//   o_ob_input_valid    order strobe to the book
//   o_ob_input_data     order word to the book
//   o_ob_start_dump     dump strobe to the book
//   i_ob_engine_busy    busy indication from the book
//   o_grant_id          index of the last granted requester (zero-extended)
//   o_orders_issued     running count of issued orders, wraps
// ---------------------------------------------------------------------------
module order_ingress_scheduler
    import order_ingress_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [ORDER_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_dump_req,
    output logic                       o_dump_done,
    output logic                       o_ob_input_valid,
    output logic [ORDER_W-1:0]         o_ob_input_data,
    output logic                       o_ob_start_dump,
    input  logic                       i_ob_engine_busy,
    output logic [GRANT_W-1:0]         o_grant_id,
    output logic [CNT_W-1:0]           o_orders_issued
);

    localparam int              SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

    sch_state_t         r_state;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [SC_W-1:0]    r_settle_cnt;
    logic               r_dump_pending;
    logic               r_op_is_dump;
    logic               r_ob_input_valid;
    logic [ORDER_W-1:0] r_ob_input_data;
    logic               r_ob_start_dump;
    logic               r_dump_done;
    logic [GRANT_W-1:0] r_grant_id;
    logic [CNT_W-1:0]   r_orders_issued;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [GRANT_W-1:0] w_arb_idx;
    logic               w_arb_any;
    logic               w_idle_free;
    logic               w_issue_dump;
    logic               w_accept;
    logic               w_dump_inflight;
    logic [ORDER_W-1:0] w_sel_data;

    order_ingress_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req       (i_req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    // A dump already pending or already issued absorbs further dump requests;
    // the in-flight window ends when the scheduler is back in IDLE.
    assign w_idle_free     = (r_state == SCH_IDLE) && !i_ob_engine_busy;
    assign w_issue_dump    = w_idle_free && r_dump_pending;
    assign w_accept        = w_idle_free && !r_dump_pending && w_arb_any;
    assign w_dump_inflight = r_op_is_dump && (r_state != SCH_IDLE);
    assign o_req_ready     = w_accept ? w_arb_grant : '0;

    // Select the winning requester's order word (grant is one-hot)
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_data = w_sel_data |
                         (i_req_data[i*ORDER_W +: ORDER_W] & {ORDER_W{w_arb_grant[i]}});
        end
    end

    // Scheduler FSM, dump bookkeeping and registered book-side outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= SCH_IDLE;
            r_rr_ptr         <= '0;
            r_settle_cnt     <= '0;
            r_dump_pending   <= 1'b0;
            r_op_is_dump     <= 1'b0;
            r_ob_input_valid <= 1'b0;
            r_ob_input_data  <= '0;
            r_ob_start_dump  <= 1'b0;
            r_dump_done      <= 1'b0;
            r_grant_id       <= '0;
            r_orders_issued  <= '0;
        end else begin
            r_ob_input_valid <= 1'b0;
            r_ob_start_dump  <= 1'b0;
            r_dump_done      <= 1'b0;

            // A request seen in the same IDLE cycle as an order only becomes
            // pending here, so that order wins and the dump goes next.
            if (w_issue_dump) begin
                r_dump_pending <= 1'b0;
            end else if (i_dump_req && !w_dump_inflight) begin
                r_dump_pending <= 1'b1;
            end else begin
                r_dump_pending <= r_dump_pending;
            end

            case (r_state)
                SCH_IDLE: begin
                    if (w_issue_dump) begin
                        r_ob_start_dump <= 1'b1;
                        r_op_is_dump    <= 1'b1;
                        r_settle_cnt    <= '0;
                        r_state         <= SCH_SETTLE;
                    end else if (w_accept) begin
                        r_ob_input_valid <= 1'b1;
                        r_ob_input_data  <= w_sel_data;
                        r_rr_ptr         <= w_arb_idx;
                        r_grant_id       <= w_arb_idx;
                        r_orders_issued  <= r_orders_issued + CNT_W'(1);
                        r_op_is_dump     <= 1'b0;
                        r_settle_cnt     <= '0;
                        r_state          <= SCH_SETTLE;
                    end else begin
                        r_state <= SCH_IDLE;
                    end
                end
                // engine_busy is not trustworthy until its assert latency has passed
                SCH_SETTLE: begin
                    if (r_settle_cnt == SC_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= SCH_WAIT_IDLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SC_W'(1);
                    end
                end
                SCH_WAIT_IDLE: begin
                    if (!i_ob_engine_busy) begin
                        r_dump_done <= r_op_is_dump;
                        r_state     <= SCH_IDLE;
                    end else begin
                        r_state <= SCH_WAIT_IDLE;
                    end
                end
                default: begin
                    r_state <= SCH_IDLE;
                end
            endcase
        end
    end

    assign o_ob_input_valid = r_ob_input_valid;
    assign o_ob_input_data  = r_ob_input_data;
    assign o_ob_start_dump  = r_ob_start_dump;
    assign o_dump_done      = r_dump_done;
    assign o_grant_id       = r_grant_id;
    assign o_orders_issued  = r_orders_issued;

endmodule

// File: tb/tb_order_ingress_scheduler.sv
// ---------------------------------------------------------------------------
// tb_order_ingress_scheduler
// Directed self-checking bench for order_ingress_scheduler (NUM_REQ = 2,
// SETTLE_CYCLES = 2). Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later; cycle 0 of every scenario is the
// first cycle after reset is released.
// ---------------------------------------------------------------------------
module tb_order_ingress_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        dump_req;
    logic        dump_done;
    logic        ob_input_valid;
    logic [31:0] ob_input_data;
    logic        ob_start_dump;
    logic        busy;
    logic [2:0]  grant_id;
    logic [31:0] orders_issued;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    order_ingress_scheduler #(
        .NUM_REQ       (2),
        .SETTLE_CYCLES (2),
        .CNT_W         (32)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .i_dump_req       (dump_req),
        .o_dump_done      (dump_done),
        .o_ob_input_valid (ob_input_valid),
        .o_ob_input_data  (ob_input_data),
        .o_ob_start_dump  (ob_start_dump),
        .i_ob_engine_busy (busy),
        .o_grant_id       (grant_id),
        .o_orders_issued  (orders_issued)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 64'h0;
        dump_req  = 1'b0;
        busy      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 7;
        if (ob_input_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", ob_input_valid); end
        if (ob_input_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h want 0", ob_input_data); end
        if (ob_start_dump !== 1'b0) begin failures++; $display("FAIL reset_start got %b want 0", ob_start_dump); end
        if (dump_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", dump_done); end
        if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        if (orders_issued !== 32'd0) begin failures++; $display("FAIL reset_count got %0d want 0", orders_issued); end
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got %b want 00", req_ready); end
    endtask

    // Requester 0 alone, two back-to-back orders, busy tied low
    task automatic test_single();
        logic [31:0] w [0:1];
        logic [31:0] vd [0:1];
        int          vc [0:1];
        int          sent = 0;
        int          nval = 0;
        logic        acc;
        logic        bad_ready = 1'b0;
        w[0] = 32'h00640105;
        w[1] = 32'h00650106;
        vc[0] = -1; vc[1] = -1; vd[0] = 32'h0; vd[1] = 32'h0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            req_valid = (sent < 2) ? 2'b01 : 2'b00;
            req_data  = {32'h0, (sent < 2) ? w[sent] : 32'h0};
            #1;
            if (ob_input_valid) begin
                if (nval < 2) begin vc[nval] = c; vd[nval] = ob_input_data; end
                nval++;
            end
            if ((req_ready & ~req_valid) != 2'b00) bad_ready = 1'b1;
            acc = req_valid[0] & req_ready[0];
            step();
            if (acc) sent++;
        end
        checks += 8;
        if (nval !== 2) begin failures++; $display("FAIL single_count got %0d want 2", nval); end
        if (vc[0] !== 1) begin failures++; $display("FAIL single_lat0 got %0d want 1", vc[0]); end
        if (vc[1] !== 5) begin failures++; $display("FAIL single_lat1 got %0d want 5", vc[1]); end
        if (vd[0] !== 32'h00640105) begin failures++; $display("FAIL single_data0 got %h want 00640105", vd[0]); end
        if (vd[1] !== 32'h00650106) begin failures++; $display("FAIL single_data1 got %h want 00650106", vd[1]); end
        if (orders_issued !== 32'd2) begin failures++; $display("FAIL single_issued got %0d want 2", orders_issued); end
        if (grant_id !== 3'd0) begin failures++; $display("FAIL single_grant got %0d want 0", grant_id); end
        if (bad_ready !== 1'b0) begin failures++; $display("FAIL single_ready_invalid got 1 want 0"); end
    endtask

    // Both requesters valid continuously: grants alternate starting at 1
    task automatic test_round_robin();
        logic [31:0] exp_d [0:4];
        logic [2:0]  exp_g [0:4];
        int          k0 = 0;
        int          k1 = 0;
        int          nval = 0;
        int          nacc = 0;
        logic [1:0]  acc;
        logic        bad_onehot = 1'b0;
        exp_d[0] = 32'hB0000000; exp_d[1] = 32'hA0000000; exp_d[2] = 32'hB0000001;
        exp_d[3] = 32'hA0000001; exp_d[4] = 32'hB0000002;
        exp_g[0] = 3'd1; exp_g[1] = 3'd0; exp_g[2] = 3'd1; exp_g[3] = 3'd0; exp_g[4] = 3'd1;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            req_valid = 2'b11;
            req_data  = {32'hB0000000 + k1, 32'hA0000000 + k0};
            #1;
            if (ob_input_valid) begin
                if (nval < 5) begin
                    checks += 3;
                    if (ob_input_data !== exp_d[nval]) begin failures++; $display("FAIL rr_data%0d got %h want %h", nval, ob_input_data, exp_d[nval]); end
                    if (grant_id !== exp_g[nval]) begin failures++; $display("FAIL rr_grant%0d got %0d want %0d", nval, grant_id, exp_g[nval]); end
                    if (orders_issued !== 32'(nval + 1)) begin failures++; $display("FAIL rr_issued%0d got %0d want %0d", nval, orders_issued, nval + 1); end
                end
                nval++;
            end
            if ($countones(req_ready) > 1) bad_onehot = 1'b1;
            acc = req_valid & req_ready;
            step();
            if (acc[0]) k0++;
            if (acc[1]) k1++;
            if (acc != 2'b00) nacc++;
        end
        checks += 3;
        if (nval !== 5) begin failures++; $display("FAIL rr_count got %0d want 5", nval); end
        if (nacc !== 5) begin failures++; $display("FAIL rr_accepts got %0d want 5", nacc); end
        if (bad_onehot !== 1'b0) begin failures++; $display("FAIL rr_onehot got 1 want 0"); end
    endtask

    // Busy rises 2 cycles after the issue and holds 10 cycles
    task automatic test_busy_pacing();
        int   sent = 0;
        int   nval = 0;
        int   vc1  = -1;
        int   first_ready = -1;
        logic acc;
        logic ready_in_busy = 1'b0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            req_valid = (sent < 2) ? 2'b01 : 2'b00;
            req_data  = {32'h0, 32'h00C80200 + sent};
            busy      = (c >= 3 && c <= 12);
            #1;
            if (ob_input_valid) begin
                if (nval == 1) vc1 = c;
                nval++;
            end
            if (c >= 1 && c <= 13 && req_ready != 2'b00) ready_in_busy = 1'b1;
            if (c >= 1 && first_ready < 0 && req_ready != 2'b00) first_ready = c;
            acc = req_valid[0] & req_ready[0];
            step();
            if (acc) sent++;
        end
        busy = 1'b0;
        checks += 4;
        if (ready_in_busy !== 1'b0) begin failures++; $display("FAIL busy_ready got 1 want 0"); end
        if (first_ready !== 14) begin failures++; $display("FAIL busy_regrant got %0d want 14", first_ready); end
        if (vc1 !== 15) begin failures++; $display("FAIL busy_issue2 got %0d want 15", vc1); end
        if (nval !== 2) begin failures++; $display("FAIL busy_count got %0d want 2", nval); end
    endtask

    // Dump requested while an order is in flight, both requesters valid
    task automatic test_dump_priority();
        int          k0 = 0;
        int          k1 = 0;
        int          nstart = 0, start_c = -1;
        int          ndone = 0, done_c = -1;
        int          nval = 0;
        int          vc [0:2];
        logic [31:0] vd [0:2];
        logic [1:0]  acc;
        logic        both = 1'b0;
        logic        ready_c4 = 1'b0;
        for (int i = 0; i < 3; i++) begin vc[i] = -1; vd[i] = 32'h0; end
        do_reset();
        for (int c = 0; c < 22; c++) begin
            req_valid = 2'b11;
            req_data  = {32'hB0000000 + k1, 32'hA0000000 + k0};
            dump_req  = (c == 1);
            busy      = (c >= 7 && c <= 12);
            #1;
            if (ob_start_dump) begin nstart++; start_c = c; end
            if (dump_done) begin ndone++; done_c = c; end
            if (ob_input_valid) begin
                if (nval < 3) begin vc[nval] = c; vd[nval] = ob_input_data; end
                nval++;
            end
            if (ob_input_valid && ob_start_dump) both = 1'b1;
            if (c == 4 && req_ready != 2'b00) ready_c4 = 1'b1;
            acc = req_valid & req_ready;
            step();
            if (acc[0]) k0++;
            if (acc[1]) k1++;
        end
        dump_req = 1'b0;
        busy     = 1'b0;
        checks += 10;
        if (nstart !== 1) begin failures++; $display("FAIL dump_starts got %0d want 1", nstart); end
        if (start_c !== 5) begin failures++; $display("FAIL dump_start_cycle got %0d want 5", start_c); end
        if (ndone !== 1) begin failures++; $display("FAIL dump_dones got %0d want 1", ndone); end
        if (done_c !== 14) begin failures++; $display("FAIL dump_done_cycle got %0d want 14", done_c); end
        if (vc[0] !== 1) begin failures++; $display("FAIL dump_order0_cycle got %0d want 1", vc[0]); end
        if (vd[0] !== 32'hB0000000) begin failures++; $display("FAIL dump_order0_data got %h want B0000000", vd[0]); end
        if (vc[1] !== 15) begin failures++; $display("FAIL dump_order1_cycle got %0d want 15", vc[1]); end
        if (vd[1] !== 32'hA0000000) begin failures++; $display("FAIL dump_order1_data got %h want A0000000", vd[1]); end
        if (both !== 1'b0) begin failures++; $display("FAIL dump_overlap got 1 want 0"); end
        if (ready_c4 !== 1'b0) begin failures++; $display("FAIL dump_ready_c4 got 1 want 0"); end
    endtask

    // Dump of an empty book (busy never rises); repeated pulses merge
    task automatic test_dump_empty();
        int nstart = 0, start_c = -1;
        int ndone = 0, done_c = -1;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            dump_req = (c <= 2);
            #1;
            if (ob_start_dump) begin nstart++; start_c = c; end
            if (dump_done) begin ndone++; done_c = c; end
            step();
        end
        dump_req = 1'b0;
        checks += 4;
        if (nstart !== 1) begin failures++; $display("FAIL empty_starts got %0d want 1", nstart); end
        if (start_c !== 2) begin failures++; $display("FAIL empty_start_cycle got %0d want 2", start_c); end
        if (ndone !== 1) begin failures++; $display("FAIL empty_dones got %0d want 1", ndone); end
        if (done_c !== 5) begin failures++; $display("FAIL empty_done_cycle got %0d want 5", done_c); end
    endtask

    // Reset during WAIT_IDLE with a dump pending and seven orders issued
    task automatic test_mid_reset();
        int   sent = 0;
        int   nval = 0;
        int   c = 0;
        int   nstart = 0, ndone = 0, nvalid_after = 0;
        logic acc;
        do_reset();
        while (nval < 7 && c < 60) begin
            req_valid = (sent < 7) ? 2'b01 : 2'b00;
            req_data  = {32'h0, 32'h00000100 + sent};
            #1;
            if (ob_input_valid) nval++;
            acc = req_valid[0] & req_ready[0];
            step();
            if (acc) sent++;
            c++;
        end
        checks += 1;
        if (nval !== 7) begin failures++; $display("FAIL midrst_setup got %0d want 7", nval); end
        req_valid = 2'b00;
        dump_req  = 1'b1;
        busy      = 1'b1;
        step();
        dump_req = 1'b0;
        step();
        #1;
        checks += 1;
        if (orders_issued !== 32'd7) begin failures++; $display("FAIL midrst_pre_count got %0d want 7", orders_issued); end
        step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        busy = 1'b0;
        #1;
        checks += 6;
        if (ob_input_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", ob_input_valid); end
        if (ob_start_dump !== 1'b0) begin failures++; $display("FAIL midrst_start got %b want 0", ob_start_dump); end
        if (dump_done !== 1'b0) begin failures++; $display("FAIL midrst_done got %b want 0", dump_done); end
        if (orders_issued !== 32'd0) begin failures++; $display("FAIL midrst_count got %0d want 0", orders_issued); end
        if (ob_input_data !== 32'h0) begin failures++; $display("FAIL midrst_data got %h want 0", ob_input_data); end
        if (req_ready !== 2'b00) begin failures++; $display("FAIL midrst_ready got %b want 00", req_ready); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (ob_start_dump) nstart++;
            if (dump_done) ndone++;
            if (ob_input_valid) nvalid_after++;
        end
        checks += 3;
        if (nstart !== 0) begin failures++; $display("FAIL midrst_no_dump got %0d want 0", nstart); end
        if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        if (nvalid_after !== 0) begin failures++; $display("FAIL midrst_no_order got %0d want 0", nvalid_after); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_pacing();
        test_dump_priority();
        test_dump_empty();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
